// File: rtl/logic_gate_pkg.sv
// rtl/logic_gate_pkg.sv - shared op codes, modes and FSM encoding for logic_gate_unit
//
// Purpose: constants and the state type shared by gate_op_core and logic_gate_unit.
// Contents: OP_AND..OP_PASS op codes, MODE_PAIR/MODE_RED, state_t, needs_invert().

package logic_gate_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOTA = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    localparam logic MODE_PAIR = 1'b0;
    localparam logic MODE_RED  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    // Ops whose final result is the complement of their base operation.
    function automatic logic needs_invert(input logic [2:0] o);
        return (o == OP_NAND) || (o == OP_NOR) || (o == OP_XNOR) || (o == OP_NOTA);
    endfunction

endpackage

// File: rtl/gate_op_core.sv
// rtl/gate_op_core.sv - combinational bitwise operator shared by pairwise, fold and finish paths
//
// Purpose: r = base(op)(x, z), optionally complemented for the inverting ops.
// Ports:
//   x, z       WIDTH-bit operands (x is the "A" side; NOT-A/PASS-A select x)
//   op         3-bit op code
//   invert_en  1 applies the complement for NAND/NOR/XNOR/NOT-A, 0 gives the base op only
//   r          WIDTH-bit result

module gate_op_core
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] z,
    input  logic [2:0]       op,
    input  logic             invert_en,
    output logic [WIDTH-1:0] r
);

    logic [WIDTH-1:0] base;

    always_comb begin
        base = x;
        case (op)
            OP_AND,  OP_NAND: base = x & z;
            OP_OR,   OP_NOR:  base = x | z;
            OP_XOR,  OP_XNOR: base = x ^ z;
            default:          base = x;
        endcase
        r = (invert_en && needs_invert(op)) ? ~base : base;
    end

endmodule

// File: rtl/logic_gate_unit.sv
// rtl/logic_gate_unit.sv - registered bitwise logic unit with pairwise and multi-beat reduce modes
//
// Purpose: applies one of eight bitwise ops to a/b, or folds a frame of a beats into one result.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   in_valid/in_ready                input handshake; a, b, op, mode, in_last are the beat
//   out_valid/out_ready              output handshake; y is the result, out_count the beats folded

module logic_gate_unit
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             mode,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;

    logic             accept;
    logic [CNT_W-1:0] cnt_inc;
    logic [WIDTH-1:0] pair_r, fold_r, g_src, g_r;
    logic [2:0]       g_op;

    assign in_ready  = (state_q != S_OUT) || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_OUT);
    assign y         = y_q;
    assign out_count = out_cnt_q;

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;

    gate_op_core #(.WIDTH(WIDTH)) u_pair (
        .x(a), .z(b), .op(op), .invert_en(1'b1), .r(pair_r)
    );

    // a sits on the x side so NOT-A/PASS-A folds keep the latest beat.
    gate_op_core #(.WIDTH(WIDTH)) u_fold (
        .x(a), .z(acc_q), .op(op_q), .invert_en(1'b0), .r(fold_r)
    );

    // Finishing step: a first-and-last beat finishes a itself, otherwise the folded acc.
    assign g_src = (state_q == S_ACC) ? fold_r : a;
    assign g_op  = (state_q == S_ACC) ? op_q : op;

    gate_op_core #(.WIDTH(WIDTH)) u_g (
        .x(g_src), .z(g_src), .op(needs_invert(g_op) ? OP_NOTA : OP_PASS),
        .invert_en(1'b1), .r(g_r)
    );

    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        out_cnt_d = out_cnt_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        case (state_q)
            S_ACC: begin
                if (accept) begin
                    acc_d = fold_r;
                    cnt_d = cnt_inc;
                    if (in_last) begin
                        y_d       = g_r;
                        out_cnt_d = cnt_inc;
                        state_d   = S_OUT;
                    end
                end
            end
            default: begin
                // S_IDLE and S_OUT: when the result is drained, a new beat may start
                // in the same cycle.
                if ((state_q == S_OUT) && out_ready) begin
                    state_d = S_IDLE;
                end
                if (accept) begin
                    if (mode == MODE_PAIR) begin
                        y_d       = pair_r;
                        out_cnt_d = CNT_ONE;
                        state_d   = S_OUT;
                    end else begin
                        op_d  = op;
                        acc_d = a;
                        cnt_d = CNT_ONE;
                        if (in_last) begin
                            y_d       = g_r;
                            out_cnt_d = CNT_ONE;
                            state_d   = S_OUT;
                        end else begin
                            state_d = S_ACC;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            y_q       <= '0;
            out_cnt_q <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            op_q      <= OP_AND;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            out_cnt_q <= out_cnt_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
        end
    end

endmodule

// File: tb/tb_logic_gate_unit.sv
// tb/tb_logic_gate_unit.sv - self-checking bench for logic_gate_unit (CNT_W=4 and CNT_W=2 instances)

module tb_logic_gate_unit;
    import logic_gate_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, mode, in_last, out_ready;
    logic [7:0] a, b;
    logic [2:0] op;

    logic       in_ready4, out_valid4, in_ready2, out_valid2;
    logic [7:0] y4, y2;
    logic [3:0] cnt4;
    logic [1:0] cnt2;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    bit         pend;
    logic [7:0] pend_y;
    int         pend_len;
    bit         open;
    logic [2:0] fop;
    logic [7:0] beats[$];

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_y;
    } pair_vec_t;
    pair_vec_t pv[8];

    logic_gate_unit #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a), .b(b), .op(op), .mode(mode), .in_last(in_last),
        .out_valid(out_valid4), .out_ready(out_ready), .y(y4), .out_count(cnt4)
    );

    logic_gate_unit #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .op(op), .mode(mode), .in_last(in_last),
        .out_valid(out_valid2), .out_ready(out_ready), .y(y2), .out_count(cnt2)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int n, input int w);
        int m = (1 << w) - 1;
        return (n > m) ? m : n;
    endfunction

    function automatic logic [7:0] ref_pair(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
        case (o)
            3'd0:    return x & z;
            3'd1:    return x | z;
            3'd2:    return x ^ z;
            3'd3:    return ~(x & z);
            3'd4:    return ~(x | z);
            3'd5:    return ~(x ^ z);
            3'd6:    return ~x;
            default: return x;
        endcase
    endfunction

    function automatic logic [7:0] ref_reduce(input logic [2:0] o, input logic [7:0] q[$]);
        logic [7:0] r;
        case (o)
            3'd0, 3'd3: begin r = 8'hFF; foreach (q[i]) r = r & q[i]; end
            3'd1, 3'd4: begin r = 8'h00; foreach (q[i]) r = r | q[i]; end
            3'd2, 3'd5: begin r = 8'h00; foreach (q[i]) r = r ^ q[i]; end
            default:    r = q[q.size() - 1];
        endcase
        if (o == 3'd3 || o == 3'd4 || o == 3'd5 || o == 3'd6) r = ~r;
        return r;
    endfunction

    // One model step per cycle, evaluated at the falling edge with inputs stable.
    task automatic model_step;
        logic rdy;
        if (rst) begin
            chk("m_rst_valid4", 32'(out_valid4), 0);
            chk("m_rst_valid2", 32'(out_valid2), 0);
            pend = 0;
            open = 0;
            beats.delete();
            return;
        end
        rdy = !pend || out_ready;
        chk("m_in_ready4", 32'(in_ready4), 32'(rdy));
        chk("m_in_ready2", 32'(in_ready2), 32'(rdy));
        chk("m_valid4", 32'(out_valid4), 32'(pend));
        chk("m_valid2", 32'(out_valid2), 32'(pend));
        if (pend) begin
            chk("m_y4", 32'(y4), 32'(pend_y));
            chk("m_y2", 32'(y2), 32'(pend_y));
            chk("m_cnt4", 32'(cnt4), sat(pend_len, 4));
            chk("m_cnt2", 32'(cnt2), sat(pend_len, 2));
        end
        if (pend && out_ready) pend = 0;
        if (in_valid && rdy) begin
            if (!open && mode == MODE_PAIR) begin
                pend     = 1;
                pend_y   = ref_pair(op, a, b);
                pend_len = 1;
            end else begin
                if (!open) begin
                    open = 1;
                    fop  = op;
                    beats.delete();
                end
                beats.push_back(a);
                if (in_last) begin
                    pend     = 1;
                    pend_y   = ref_reduce(fop, beats);
                    pend_len = beats.size();
                    open     = 0;
                end
            end
        end
    endtask

    task automatic tick;
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic md, input logic [2:0] o,
                         input logic [7:0] aa, input logic [7:0] bb, input logic l);
        in_valid = v; mode = md; op = o; a = aa; b = bb; in_last = l;
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b1;
        drive(0, 0, 0, 8'h00, 8'h00, 0);
        pv[0] = '{OP_AND,  8'hF0, 8'hCC, 8'hC0};
        pv[1] = '{OP_OR,   8'hF0, 8'hCC, 8'hFC};
        pv[2] = '{OP_XOR,  8'hF0, 8'hCC, 8'h3C};
        pv[3] = '{OP_NAND, 8'hF0, 8'hCC, 8'h3F};
        pv[4] = '{OP_NOR,  8'hF0, 8'hCC, 8'h03};
        pv[5] = '{OP_XNOR, 8'hF0, 8'hCC, 8'hC3};
        pv[6] = '{OP_NOTA, 8'hF0, 8'hCC, 8'h0F};
        pv[7] = '{OP_PASS, 8'hF0, 8'hCC, 8'hF0};

        // reset state
        tick; tick;
        chk("rst_valid", 32'(out_valid4), 0);
        chk("rst_y", 32'(y4), 0);
        chk("rst_cnt", 32'(cnt4), 0);
        chk("rst_in_ready", 32'(in_ready4), 1);
        chk("rst_cnt2", 32'(cnt2), 0);
        rst = 1'b0;
        tick;

        // pairwise sweep, back to back
        for (int i = 0; i < 8; i++) begin
            drive(1, MODE_PAIR, pv[i].op, pv[i].a, pv[i].b, 0);
            #1;
            chk("sweep_in_ready", 32'(in_ready4), 1);
            tick;
            chk("sweep_valid", 32'(out_valid4), 1);
            chk("sweep_y", 32'(y4), 32'(pv[i].exp_y));
            chk("sweep_cnt", 32'(cnt4), 1);
        end
        drive(0, 0, 0, 8'h00, 8'h00, 0);
        tick;
        chk("sweep_drain", 32'(out_valid4), 0);

        // reduce AND frame with op/mode changes mid-frame
        drive(1, MODE_RED, OP_AND, 8'hFF, 8'h00, 0); tick;
        chk("and_mid1", 32'(out_valid4), 0);
        drive(1, MODE_PAIR, OP_NAND, 8'h7E, 8'h11, 0); tick;
        chk("and_mid2", 32'(out_valid4), 0);
        drive(1, MODE_PAIR, OP_NOTA, 8'h3C, 8'h22, 1); tick;
        chk("and_valid", 32'(out_valid4), 1);
        chk("and_y", 32'(y4), 'h3C);
        chk("and_cnt", 32'(cnt4), 3);
        drive(0, 0, 0, 8'h00, 8'h00, 0); tick;

        // reduce NOR single beat
        drive(1, MODE_RED, OP_NOR, 8'h00, 8'h00, 1); tick;
        chk("nor_y", 32'(y4), 'hFF);
        chk("nor_cnt", 32'(cnt4), 1);
        drive(0, 0, 0, 8'h00, 8'h00, 0); tick;

        // backpressure
        out_ready = 1'b0;
        drive(1, MODE_PAIR, OP_XOR, 8'h5A, 8'h0F, 0); tick;
        drive(1, MODE_PAIR, OP_AND, 8'hFF, 8'h81, 0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(out_valid4), 1);
            chk("bp_y", 32'(y4), 'h55);
            chk("bp_in_ready", 32'(in_ready4), 0);
            tick;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready4), 1);
        tick;
        chk("bp_next_valid", 32'(out_valid4), 1);
        chk("bp_next_y", 32'(y4), 'h81);
        drive(0, 0, 0, 8'h00, 8'h00, 0); tick;
        chk("bp_drain", 32'(out_valid4), 0);

        // counter saturation: 6-beat XOR frame
        for (int i = 0; i < 6; i++) begin
            drive(1, MODE_RED, OP_XOR, 8'(1 << i), 8'h00, (i == 5));
            tick;
        end
        chk("sat_y4", 32'(y4), 'h3F);
        chk("sat_cnt4", 32'(cnt4), 6);
        chk("sat_y2", 32'(y2), 'h3F);
        chk("sat_cnt2", 32'(cnt2), 3);
        drive(0, 0, 0, 8'h00, 8'h00, 0); tick;

        // reset mid-frame, then a fresh frame with an idle gap
        drive(1, MODE_RED, OP_AND, 8'h0F, 8'h00, 0); tick;
        drive(1, MODE_RED, OP_AND, 8'h0F, 8'h00, 0); tick;
        drive(0, 0, 0, 8'h00, 8'h00, 0);
        rst = 1'b1;
        #1;
        chk("rstmid_valid", 32'(out_valid4), 0);
        chk("rstmid_y", 32'(y4), 0);
        tick;
        rst = 1'b0;
        tick;
        drive(1, MODE_RED, OP_AND, 8'hF0, 8'h00, 0); tick;
        drive(0, 0, 0, 8'h00, 8'h00, 0); tick;
        chk("gap_hold", 32'(out_valid4), 0);
        drive(1, MODE_RED, OP_AND, 8'hF0, 8'h00, 1); tick;
        chk("rstmid_next_y", 32'(y4), 'hF0);
        chk("rstmid_next_cnt", 32'(cnt4), 2);
        drive(0, 0, 0, 8'h00, 8'h00, 0); tick;

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            mode      = 1'($urandom_range(0, 1));
            op        = 3'($urandom_range(0, 7));
            a         = 8'($urandom);
            b         = 8'($urandom);
            in_last   = ($urandom_range(0, 3) == 0);
            tick;
        end
        rst = 1'b0; out_ready = 1'b1;
        drive(0, 0, 0, 8'h00, 8'h00, 0);
        tick; tick; tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
